// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control/status bundle between the controlling FSM (master)
// and the lfsr_gen register (slave). clk and rst_n stay plain ports on the
// design. WIDTH and CNT_W must match the parameters of the attached lfsr_gen.
interface lfsr_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             lfsr_init;
  logic [WIDTH-1:0] lfsr_tab;
  logic [WIDTH-1:0] lfsr_init_state;
  logic             mode;
  logic             lfsr_en;
  logic             run_start;
  logic [CNT_W-1:0] run_len;
  logic             busy;
  logic             done;
  logic             lockup;
  logic [WIDTH-1:0] state_o;
  logic             bit_o;

  modport master (
    output lfsr_init, lfsr_tab, lfsr_init_state, mode, lfsr_en, run_start, run_len,
    input  busy, done, lockup, state_o, bit_o
  );

  modport slave (
    input  lfsr_init, lfsr_tab, lfsr_init_state, mode, lfsr_en, run_start, run_len,
    output busy, done, lockup, state_o, bit_o
  );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with Fibonacci/Galois feedback, single-step
// and counted multi-step run with a busy/done handshake.
// Optional feature: define LFSR_GEN_LOCKUP_RECOVER_EN to reload SEED when a
// shift is due from the all-zero state and raise the sticky lockup flag.
// Without it, all-zero is a fixed point and lockup is always 0.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_gen_if.slave  bus
);

`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
  localparam bit RECOVER_EN = 1'b1;
`else
  localparam bit RECOVER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] shift_next;
  logic             do_shift;

  // Candidate successor of the current register under the latched taps/mode.
  always_comb begin
    fib_next   = {^(lfsr_q & taps_q), lfsr_q[WIDTH-1:1]};
    gal_next   = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
    shift_next = mode_q ? gal_next : fib_next;
  end

  // Next-state logic: init wins over everything, then the FSM decides
  // whether this edge shifts; a due shift from all-zero may recover to SEED.
  always_comb begin
    fsm_d    = fsm_q;
    lfsr_d   = lfsr_q;
    taps_d   = taps_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    lockup_d = lockup_q;
    do_shift = 1'b0;

    if (bus.lfsr_init) begin
      lfsr_d   = bus.lfsr_init_state;
      taps_d   = bus.lfsr_tab;
      mode_d   = bus.mode;
      cnt_d    = '0;
      lockup_d = 1'b0;
      fsm_d    = IDLE;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.run_start) begin
            if (bus.run_len == '0) begin
              fsm_d = DONE;
            end else begin
              cnt_d = bus.run_len;
              fsm_d = RUN;
            end
          end else if (bus.lfsr_en) begin
            do_shift = 1'b1;
          end
        end
        RUN: begin
          do_shift = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            fsm_d = DONE;
          end
        end
        DONE: begin
          fsm_d = IDLE;
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase

      if (do_shift) begin
        if (RECOVER_EN && (lfsr_q == '0)) begin
          lfsr_d   = SEED;
          lockup_d = 1'b1;
        end else begin
          lfsr_d = shift_next;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      lfsr_q   <= SEED;
      taps_q   <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      taps_q   <= taps_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.busy    = (fsm_q == RUN);
  assign bus.done    = (fsm_q == DONE);
  assign bus.lockup  = lockup_q;
  assign bus.state_o = lfsr_q;
  assign bus.bit_o   = lfsr_q[0];

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed self-checking bench for lfsr_gen (WIDTH=8, CNT_W=8).
// Expected lock-up behaviour follows LFSR_GEN_LOCKUP_RECOVER_EN.
module tb_lfsr_gen;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;

  lfsr_gen_if #(.WIDTH(8), .CNT_W(8)) bus ();

  lfsr_gen #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the edge take them, then return strobes low
  task automatic applyStimulus(input logic init, input logic [7:0] tab, input logic [7:0] init_state,
                               input logic md, input logic en, input logic start, input logic [7:0] len);
    bus.lfsr_init       = init;
    bus.lfsr_tab        = tab;
    bus.lfsr_init_state = init_state;
    bus.mode            = md;
    bus.lfsr_en         = en;
    bus.run_start       = start;
    bus.run_len         = len;
    stepCycle();
    bus.lfsr_init = 1'b0;
    bus.lfsr_en   = 1'b0;
    bus.run_start = 1'b0;
  endtask

  initial begin
    logic [7:0] lockExp0;
    logic [7:0] lockExp1;
    logic       lockFlag;
    checkCount = 0;
    failCount  = 0;
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
    lockExp0 = 8'h01;
    lockExp1 = 8'h00;
    lockFlag = 1'b1;
`else
    lockExp0 = 8'h00;
    lockExp1 = 8'h00;
    lockFlag = 1'b0;
`endif

    bus.lfsr_init       = 1'b0;
    bus.lfsr_tab        = 8'h00;
    bus.lfsr_init_state = 8'h00;
    bus.mode            = 1'b0;
    bus.lfsr_en         = 1'b0;
    bus.run_start       = 1'b0;
    bus.run_len         = 8'h00;
    rst_n = 1'b0;
    repeat (2) stepCycle();
    checkOutput("reset_state", 32'(bus.state_o), 32'h01);
    checkOutput("reset_bit", 32'(bus.bit_o), 32'h1);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'h0);
    checkOutput("reset_lockup", 32'(bus.lockup), 32'h0);
    rst_n = 1'b1;
    stepCycle();

    // Fibonacci single steps
    applyStimulus(1'b1, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("fib_init", 32'(bus.state_o), 32'hE1);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("fib_step1", 32'(bus.state_o), 32'h70);
    checkOutput("fib_bit1", 32'(bus.bit_o), 32'h0);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("fib_step2", 32'(bus.state_o), 32'h38);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("fib_step3", 32'(bus.state_o), 32'h9C);
    stepCycle();
    checkOutput("fib_hold", 32'(bus.state_o), 32'h9C);

    // Galois single steps, then a live tap/mode change that must be ignored
    applyStimulus(1'b1, 8'hB8, 8'hE1, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b1, 1'b1, 1'b0, 8'd0);
    checkOutput("gal_step1", 32'(bus.state_o), 32'hC8);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b1, 1'b1, 1'b0, 8'd0);
    checkOutput("gal_step2", 32'(bus.state_o), 32'h64);
    applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("gal_live_tab", 32'(bus.state_o), 32'h32);

    // Counted run of 3, with a run_start while busy that must be dropped
    applyStimulus(1'b1, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b1, 8'd3);
    checkOutput("run_busy1", 32'(bus.busy), 32'h1);
    checkOutput("run_noshift", 32'(bus.state_o), 32'hE1);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b1, 8'd5);
    checkOutput("run_busy2", 32'(bus.busy), 32'h1);
    checkOutput("run_state2", 32'(bus.state_o), 32'h70);
    stepCycle();
    checkOutput("run_busy3", 32'(bus.busy), 32'h1);
    checkOutput("run_done_early", 32'(bus.done), 32'h0);
    stepCycle();
    checkOutput("run_busy_end", 32'(bus.busy), 32'h0);
    checkOutput("run_done", 32'(bus.done), 32'h1);
    checkOutput("run_state", 32'(bus.state_o), 32'h9C);
    stepCycle();
    checkOutput("run_done_pulse", 32'(bus.done), 32'h0);
    checkOutput("run_not_queued", 32'(bus.busy), 32'h0);
    checkOutput("run_state_hold", 32'(bus.state_o), 32'h9C);

    // Zero-length run, then lfsr_en during DONE is ignored
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("zero_done", 32'(bus.done), 32'h1);
    checkOutput("zero_busy", 32'(bus.busy), 32'h0);
    checkOutput("zero_state", 32'(bus.state_o), 32'h9C);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("done_en_ignored", 32'(bus.state_o), 32'h9C);
    checkOutput("zero_done_pulse", 32'(bus.done), 32'h0);

    // All-zero state behaviour
    applyStimulus(1'b1, 8'hB8, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'hB8, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("lock_state1", 32'(bus.state_o), 32'(lockExp0));
    checkOutput("lock_flag1", 32'(bus.lockup), 32'(lockFlag));
    applyStimulus(1'b0, 8'hB8, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("lock_state2", 32'(bus.state_o), 32'(lockExp1));
    checkOutput("lock_sticky", 32'(bus.lockup), 32'(lockFlag));
    applyStimulus(1'b1, 8'hB8, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("lock_clear", 32'(bus.lockup), 32'h0);
    checkOutput("lock_init_state", 32'(bus.state_o), 32'h5A);

    // Abort a 10-shift run with lfsr_init on the 4th busy cycle
    applyStimulus(1'b1, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'hB8, 8'hE1, 1'b0, 1'b0, 1'b1, 8'd10);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("abort_busy", 32'(bus.busy), 32'h1);
    end
    applyStimulus(1'b1, 8'hB8, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("abort_state", 32'(bus.state_o), 32'h5A);
    checkOutput("abort_busy_low", 32'(bus.busy), 32'h0);
    checkOutput("abort_no_done", 32'(bus.done), 32'h0);
    stepCycle();
    checkOutput("abort_no_done2", 32'(bus.done), 32'h0);

    // Asynchronous reset in the middle of a run
    applyStimulus(1'b1, 8'hB8, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'hB8, 8'h00, 1'b0, 1'b0, 1'b1, 8'd10);
    stepCycle();
    stepCycle();
    checkOutput("rst_pre_busy", 32'(bus.busy), 32'h1);
    checkOutput("rst_pre_lockup", 32'(bus.lockup), 32'(lockFlag));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_state", 32'(bus.state_o), 32'h01);
    checkOutput("rst_async_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_async_done", 32'(bus.done), 32'h0);
    checkOutput("rst_async_lockup", 32'(bus.lockup), 32'h0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_release_done", 32'(bus.done), 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1);
    checkOutput("rst_new_run_busy", 32'(bus.busy), 32'h1);
    stepCycle();
    checkOutput("rst_new_run_done", 32'(bus.done), 32'h1);
    checkOutput("rst_new_run_state", 32'(bus.state_o), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register: the successor to the team's fixed 8-bit LFSR. It generalises width, adds a selectable Fibonacci or Galois feedback form, and adds a counted multi-step "run" command with a busy/done handshake. It sits in the pseudo-random stimulus and scrambler paths and is driven by a controlling FSM. That FSM either single-steps the register or requests N shifts and waits for `done`.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits (≥ 2).
- `CNT_W`, 8: width of the `run_len` input.
- `SEED`, `{{(WIDTH-1){1'b0}},1'b1}`: value loaded at reset and on lock-up recovery; must be non-zero.

Ports:
- `clk`  in  1: the block's single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `lfsr_init`  in  1: load `lfsr_init_state`, latch `lfsr_tab` and `mode`, abort any run.
- `lfsr_tab`  in  WIDTH: tap mask.
- `lfsr_init_state`  in  WIDTH: value loaded by `lfsr_init`.
- `mode`  in  1: 0 = Fibonacci, 1 = Galois; latched with the taps.
- `lfsr_en`  in  1: single shift this cycle; honoured only in IDLE.
- `run_start`  in  1: request `run_len` shifts; honoured only in IDLE.
- `run_len`  in  CNT_W: shift count, sampled with `run_start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse after a run completes.
- `lockup`  out  1: sticky all-zero recovery flag.
- `state_o`  out  WIDTH: current register value.
- `bit_o`  out  1: equals `state_o[0]`.

## Operation
- Reset values:
  - `state_o` = SEED.
  - Latched taps = 0; latched mode = 0.
  - FSM = IDLE.
  - `busy`, `done` and `lockup` = 0.
- Shift function on state `s` with latched taps `t`:
  - Fibonacci: next = `{^(s & t), s[WIDTH-1:1]}`.
  - Galois: next = `(s >> 1) ^ (s[0] ? t : 0)`.
- FSM states:
  - IDLE:
    - `lfsr_init` → load; stay IDLE.
    - else `run_start` with `run_len` = 0 → DONE, no shift.
    - else `run_start` with `run_len` > 0 → load counter = `run_len`, go RUN, no shift on this edge.
    - else `lfsr_en` → one shift.
  - RUN: on each edge, shift and decrement the counter. When the counter is 1 on that edge → DONE.
  - DONE: `done` = 1 for this one cycle, then → IDLE. `lfsr_en` and `run_start` are ignored in DONE.
- Priority: `lfsr_init` > RUN > `run_start` > `lfsr_en`.
- `lfsr_init` in RUN or DONE:
  - loads the register and returns to IDLE;
  - no `done` is issued;
  - the counter is cleared;
  - `lockup` is cleared.
- `lfsr_en` and `run_start` asserted while in RUN: ignored and not queued.
- Taps and mode change only on `lfsr_init`. Live `lfsr_tab`/`mode` changes have no effect until the next init.

## Timing
- Shifts happen on register update, so `state_o` changes the cycle after the enabling edge.
- `run_start` sampled at edge E with N > 0:
  - `busy` is high from E through E+N;
  - shifts occur at edges E+1 … E+N;
  - `done` is high between edges E+N and E+N+1.
- `run_len` = 0: `done` is high the cycle after the start edge; `busy` never rises.
- Back-to-back runs: the earliest accepted next `run_start` is at the edge ending DONE's successor IDLE cycle. Minimum start-to-start spacing is N+2 cycles.
- `rst_n` low asynchronously forces all reset values, mid-run included; `done` is never emitted for an aborted run.

## Configuration
- `LFSR_GEN_LOCKUP_RECOVER_EN` defined:
  - When a shift (step or run) is due and the current state is all-zero, the register loads SEED instead of shifting.
  - `lockup` is set and stays high until `lfsr_init` or reset.
  - A run still counts that cycle as one of its N shifts.
- Not defined:
  - An all-zero state shifts to all-zero (a fixed point in both modes).
  - `lockup` is tied to 0.

## Test plan
- Fibonacci step: WIDTH=8, init with tab 8'hB8, state 8'hE1, mode 0; three `lfsr_en` pulses → `state_o` = 8'h70, 8'h38, 8'h9C.
- Galois step: same init, mode 1; two `lfsr_en` pulses → 8'hC8, then 8'h64.
- Run handshake: Fibonacci from 8'hE1, `run_start` with `run_len`=3:
  - `busy` is high for 3 cycles; `done` pulses once, next cycle; `state_o` = 8'h9C.
  - A `run_start` while `busy` is ignored.
  - `run_len`=0 → `done` the next cycle with the state unchanged.
- Lock-up, with the macro defined: init state 8'h00, then one `lfsr_en` → `state_o` = 8'h01 and `lockup` = 1. `lockup` stays 1 until `lfsr_init`. Without the macro: `state_o` stays 8'h00 and `lockup` = 0.
- Abort: `run_len`=10, then `lfsr_init` (state 8'h5A) on the 4th busy cycle → `state_o` = 8'h5A, `busy` = 0 next cycle, no `done` pulse.
- Reset mid-run: drop `rst_n` asynchronously while `busy` → immediately `state_o` = SEED and `busy`/`done`/`lockup` = 0. After release, the FSM is idle and accepts a new `run_start`.
